apb_slave_regbank: RTL and testbench

APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

---
 rtl/apb_slave_regbank_pkg.sv | 15 +
 rtl/apb_phase_fsm.sv | 80 ++++++++
 rtl/apb_slave_regbank.sv | 95 +++++++++
 tb/tb_apb_slave_regbank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_regbank_pkg.sv
// Shared definitions for the APB slave register bank: phase FSM states,
// bank geometry and the default identification word.
package apb_slave_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  localparam int          REG_COUNT  = 16;
  localparam int          IDX_W      = 4;
  localparam logic [31:0] DEFAULT_ID = 32'hA2B0_0001;

endpackage

// File: rtl/apb_phase_fsm.sv
// APB phase tracker. The state register lags the bus by one cycle: SETUP
// means "the previous cycle was a setup phase", so the current cycle is the
// access phase. Protocol checks and the commit/load strobes are decoded
// combinationally so the bank can act on the very edge that ends a phase.
module apb_phase_fsm
  import apb_slave_regbank_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        sel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  output logic        wr_commit,
  output logic        rd_load,
  output logic        err_pulse
);

  apb_phase_e  state_reg;
  apb_phase_e  state_next;
  logic        pwrite_reg;
  logic [31:0] paddr_reg;
  logic        setup_req;
  logic        access_bad;

  assign setup_req  = sel && !penable;
  // Access phase must keep select/enable asserted and hold the setup-phase
  // direction and address.
  assign access_bad = !sel || !penable || (pwrite != pwrite_reg) || (paddr != paddr_reg);

  // Next-state and strobe decode; a violation always falls back to IDLE, or
  // to SETUP when the current cycle is itself a fresh setup phase.
  always_comb begin
    state_next = state_reg;
    wr_commit  = 1'b0;
    err_pulse  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel && penable) begin
          err_pulse = 1'b1;
        end
        state_next = setup_req ? SETUP : IDLE;
      end
      SETUP: begin
        if (access_bad) begin
          err_pulse  = 1'b1;
          state_next = setup_req ? SETUP : IDLE;
        end else begin
          wr_commit  = pwrite;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = setup_req ? SETUP : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Any entry into SETUP is a setup phase; a read loads data for the
    // access cycle that follows (also after a violation that restarts).
    rd_load = (state_next == SETUP) && !pwrite;
  end

  // State register plus capture of the setup-phase direction and address.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_reg  <= IDLE;
      pwrite_reg <= 1'b0;
      paddr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == SETUP) begin
        pwrite_reg <= pwrite;
        paddr_reg  <= paddr;
      end
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// Zero-wait-state APB slave with a 16 x 32-bit register bank. Registers
// 0-14 are read/write, register 15 is a read-only ID word. Also exports a
// saturating committed-write counter and a sticky protocol-error flag.
module apb_slave_regbank
  import apb_slave_regbank_pkg::*;
#(
  parameter int          SEL_BIT  = 0,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic [15:0] wr_count,
  output logic        proto_err
);

  logic                           sel;
  logic [IDX_W-1:0]               idx;
  logic                           wr_commit;
  logic                           rd_load;
  logic                           err_pulse;
  logic [REG_COUNT-1:0][31:0]     bank_q;
  logic                           unused_pselx;

  assign sel          = Pselx[SEL_BIT];
  assign idx          = Paddr[5:2];
  // Other select bits belong to sibling slaves and are deliberately ignored.
  assign unused_pselx = ^Pselx;

  apb_phase_fsm u_fsm (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .sel       (sel),
    .penable   (Penable),
    .pwrite    (Pwrite),
    .paddr     (Paddr),
    .wr_commit (wr_commit),
    .rd_load   (rd_load),
    .err_pulse (err_pulse)
  );

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT - 1; gi++) begin : g_reg
      logic [31:0] word_reg;

      // Writable register: loads Pwdata when a commit targets this index.
      always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
          word_reg <= '0;
        end else if (wr_commit && (idx == IDX_W'(gi))) begin
          word_reg <= Pwdata;
        end
      end

      assign bank_q[gi] = word_reg;
    end
  endgenerate

  // Top slot is the constant ID; writes to it are counted but dropped.
  assign bank_q[REG_COUNT-1] = ID_VALUE;

  // Read data is captured at the end of a read setup phase and then held.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Prdata <= '0;
    end else if (rd_load) begin
      Prdata <= bank_q[idx];
    end
  end

  // Committed-write counter, saturating at all-ones.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      wr_count <= '0;
    end else if (wr_commit && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      proto_err <= 1'b0;
    end else if (err_pulse) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench for apb_slave_regbank: a reference bank model feeds a
// queue of expected read data when each read setup is driven; entries are
// popped and compared in the matching access cycle.
module tb_apb_slave_regbank;
  import apb_slave_regbank_pkg::*;

  logic        Hclk;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic [15:0] wr_count;
  logic        proto_err;

  int          err_cnt   = 0;
  int          check_cnt = 0;
  logic [31:0] model [REG_COUNT];
  logic [15:0] exp_cnt;
  logic        exp_err;
  logic [31:0] last_rd;
  logic [31:0] exp_q [$];

  apb_slave_regbank dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .wr_count  (wr_count),
    .proto_err (proto_err)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: act=%08h exp=%08h", tag, act, exp);
    end else begin
      $display("ok   %s: %08h", tag, act);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_COUNT - 1; i++) model[i] = 32'h0;
    model[REG_COUNT-1] = 32'hA2B0_0001;
    exp_cnt = 16'h0;
    exp_err = 1'b0;
    last_rd = 32'h0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_cnt"}, 32'(wr_count), 32'(exp_cnt));
    check_eq({tag, "_err"}, 32'(proto_err), 32'(exp_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Hclk);
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    end
  endtask

  // One APB transfer (setup + access). b2b: the previous cycle was an access
  // phase, so the phase tracker must be in ACCESS at this setup.
  task automatic xfer(input logic [2:0] sx, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic b2b);
    logic [3:0]  i;
    logic [31:0] exp;
    i = addr[5:2];
    @(negedge Hclk);
    if (b2b) check_eq("st_b2b", 32'(dut.u_fsm.state_reg), 32'(ACCESS));
    Pselx = sx; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
    if (!wr && sx[0]) exp_q.push_back(model[i]);
    @(negedge Hclk);
    Penable = 1'b1;
    if (sx[0]) begin
      check_eq("st_setup", 32'(dut.u_fsm.state_reg), 32'(SETUP));
      if (!wr) begin
        if (exp_q.size() == 0) begin
          check_eq("q_empty", 32'd0, 32'd1);
        end else begin
          exp = exp_q.pop_front();
          check_eq($sformatf("rd%0d", i), Prdata, exp);
          last_rd = exp;
        end
      end else begin
        check_eq("rd_hold", Prdata, last_rd);
        if (i != 4'd15) model[i] = data;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Hclk);
    Hresetn = 1'b0;
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    model_reset();
    #1;
    check_eq("rst_rdata", Prdata, 32'h0);
    check_eq("rst_state", 32'(dut.u_fsm.state_reg), 32'(IDLE));
    check_status("rst");
    @(negedge Hclk);
    Hresetn = 1'b1;
  endtask

  initial begin
    Hresetn = 1'b1;
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    model_reset();
    do_reset();

    // Write then read back through an address with ignored upper bits.
    xfer(3'b001, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0);
    xfer(3'b001, 1'b0, 32'h8000_0008, 32'h0, 1'b1);
    idle(1);
    check_status("wr_rd");

    // ID register: read, attempt overwrite, read again.
    xfer(3'b001, 1'b0, 32'h8000_003C, 32'h0, 1'b0);
    xfer(3'b001, 1'b1, 32'h8000_003C, 32'h0, 1'b1);
    xfer(3'b001, 1'b0, 32'h8000_003C, 32'h0, 1'b1);
    idle(1);
    check_status("id");

    // Four back-to-back writes, then four back-to-back reads (mixed Pselx).
    for (int k = 0; k < 4; k++)
      xfer(3'b001, 1'b1, 32'(k * 4), 32'(k + 1), k != 0);
    for (int k = 0; k < 4; k++)
      xfer((k % 2 == 0) ? 3'b111 : 3'b101, 1'b0, 32'(k * 4), 32'h0, 1'b1);
    // Write to the index just read: held read data must not change.
    xfer(3'b001, 1'b1, 32'h0000_000C, 32'h0000_0055, 1'b1);
    idle(1);
    check_status("b2b");

    // A transfer addressed to another slave must be ignored.
    xfer(3'b110, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0);
    idle(1);
    xfer(3'b001, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    idle(1);
    check_status("other_sel");

    // Address changes between setup and access on a write.
    @(negedge Hclk);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h8; Pwdata = 32'hBAD0_0002;
    @(negedge Hclk);
    Penable = 1'b1; Paddr = 32'hC;
    exp_err = 1'b1;
    idle(1);
    check_eq("viol_state", 32'(dut.u_fsm.state_reg), 32'(IDLE));
    check_status("viol");
    xfer(3'b001, 1'b0, 32'h8, 32'h0, 1'b0);
    xfer(3'b001, 1'b0, 32'hC, 32'h0, 1'b1);
    idle(1);

    // Reset pulse between setup and access of a write aborts it.
    do_reset();
    xfer(3'b001, 1'b0, 32'h3C, 32'h0, 1'b0);
    @(negedge Hclk);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'hCAFE_0000;
    @(negedge Hclk);
    Penable = 1'b1;
    Hresetn = 1'b0;
    model_reset();
    #1;
    check_eq("abort_rdata", Prdata, 32'h0);
    check_status("abort");
    @(negedge Hclk);
    Hresetn = 1'b1; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    xfer(3'b001, 1'b0, 32'h14, 32'h0, 1'b0);
    xfer(3'b001, 1'b1, 32'h14, 32'hCAFE_0005, 1'b1);
    xfer(3'b001, 1'b0, 32'h14, 32'h0, 1'b1);
    idle(1);
    check_status("post_abort");

    // Select dropped in the access cycle: error, no commit, no count.
    @(negedge Hclk);
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h18; Pwdata = 32'h6666_6666;
    @(negedge Hclk);
    Pselx = 3'b000; Penable = 1'b1;
    exp_err = 1'b1;
    idle(1);
    check_status("seldrop");
    xfer(3'b001, 1'b0, 32'h18, 32'h0, 1'b0);
    idle(1);

    // Counter saturation from 16'hFFFE.
    @(negedge Hclk);
    force dut.wr_count = 16'hFFFE;
    @(negedge Hclk);
    release dut.wr_count;
    exp_cnt = 16'hFFFE;
    check_status("preset");
    xfer(3'b001, 1'b1, 32'h20, 32'h0000_0001, 1'b0);
    idle(1);
    check_status("sat1");
    xfer(3'b001, 1'b1, 32'h24, 32'h0000_0002, 1'b0);
    xfer(3'b001, 1'b1, 32'h28, 32'h0000_0003, 1'b1);
    idle(1);
    check_status("sat3");

    // Enable asserted while idle is a protocol error.
    do_reset();
    @(negedge Hclk);
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b0; Paddr = 32'h0;
    exp_err = 1'b1;
    idle(1);
    check_status("idle_en");

    check_eq("q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
